// File: rtl/crossy_robbers_soc_keycode_in_if.sv
// Avalon-MM slave bus bundle for the keycode input block.
// The master drives address/strobes/writedata; the slave returns readdata.
interface crossy_robbers_soc_keycode_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output read_n,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  read_n,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/crossy_robbers_soc_keycode_in.sv
// Keycode input port: synchronises an asynchronous keycode from the fabric, logs every
// value change into a small event FIFO and exposes live value, events, status and a
// maskable level IRQ to the CPU over Avalon-MM (zero wait-state reads).
// Optional feature: define KEYCODE_IN_DEBOUNCE_EN to insert a debounce stage that only
// accepts a value after it has been stable for DEBOUNCE_CYCLES cycles.
module crossy_robbers_soc_keycode_in #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  crossy_robbers_soc_keycode_in_if.slave  avs,
  input  logic [DATA_WIDTH-1:0]           in_port,
  output logic                            irq
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] AddrData   = 2'd0;
  localparam logic [1:0] AddrMask   = 2'd1;
  localparam logic [1:0] AddrEvent  = 2'd2;
  localparam logic [1:0] AddrStatus = 2'd3;

  logic [DATA_WIDTH-1:0] r_sync1;
  logic [DATA_WIDTH-1:0] r_sync2;
  logic [DATA_WIDTH-1:0] r_prev;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]       r_wptr;
  logic [PtrW-1:0]       r_rptr;
  logic [CntW-1:0]       r_count;
  logic                  r_overflow;
  logic                  r_irq_mask;
  logic                  r_irq;

  logic [DATA_WIDTH-1:0] w_sample;
  logic                  w_sample_vld;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_change;
  logic                  w_rd_strobe;
  logic                  w_wr_strobe;
  logic                  w_pop_req;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_flush;
  logic                  w_ovf_clr;
  logic                  w_unused;

  // Two-flop synchroniser for the asynchronous keycode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

`ifdef KEYCODE_IN_DEBOUNCE_EN
  localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DATA_WIDTH-1:0] r_cand;
  logic [DebW-1:0]       r_deb_cnt;

  // Track a candidate value; the counter saturates once it has been stable long enough
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cand    <= '0;
      r_deb_cnt <= '0;
    end else if (r_sync2 != r_cand) begin
      r_cand    <= r_sync2;
      r_deb_cnt <= '0;
    end else if (r_deb_cnt != DebW'(DEBOUNCE_CYCLES)) begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  assign w_sample     = r_cand;
  assign w_sample_vld = (r_deb_cnt == DebW'(DEBOUNCE_CYCLES));
  // prev only ever holds accepted values, so it is the debounced live value
  assign w_data       = r_prev;
  assign w_unused     = ^avs.writedata[31:2];
`else
  logic [31:0] w_unused_deb;

  assign w_sample     = r_sync2;
  assign w_sample_vld = 1'b1;
  assign w_data       = r_sync2;
  assign w_unused_deb = 32'(DEBOUNCE_CYCLES);
  assign w_unused     = ^avs.writedata[31:2];
`endif

  // Bus decode and FIFO push/pop arbitration
  always_comb begin
    w_rd_strobe = avs.chipselect & ~avs.read_n;
    w_wr_strobe = avs.chipselect & ~avs.write_n;
    w_pop_req   = w_rd_strobe & (avs.address == AddrEvent);
    w_flush     = w_wr_strobe & (avs.address == AddrStatus) & avs.writedata[1];
    w_ovf_clr   = w_wr_strobe & (avs.address == AddrStatus) & avs.writedata[0];
    w_empty     = (r_count == '0);
    w_full      = (r_count == CntW'(FIFO_DEPTH));
    w_change    = w_sample_vld & (w_sample != r_prev);
    w_pop       = w_pop_req & ~w_empty & ~w_flush;
    // A same-cycle pop frees the slot a full FIFO needs; flush discards the push outright
    w_push      = w_change & (~w_full | w_pop) & ~w_flush;
    w_drop      = w_change & w_full & ~w_pop & ~w_flush;
  end

  // Change detector: prev follows every accepted value, even when the push is dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= '0;
    end else if (w_change) begin
      r_prev <= w_sample;
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_sample;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as FIFO_DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow (a new overflow beats a same-cycle clear) and the IRQ mask bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
      r_irq_mask <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_ovf_clr) begin
        r_overflow <= 1'b0;
      end
      if (w_wr_strobe && (avs.address == AddrMask)) begin
        r_irq_mask <= avs.writedata[0];
      end
    end
  end

  // Registered level interrupt, one cycle behind pending/overflow state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_mask & (~w_empty | r_overflow);
    end
  end

  assign irq = r_irq;

  // Zero wait-state read mux; every field is zero while in reset
  always_comb begin
    avs.readdata = '0;
    case (avs.address)
      AddrData: begin
        avs.readdata[DATA_WIDTH-1:0] = w_data;
      end
      AddrMask: begin
        avs.readdata[0] = r_irq_mask;
      end
      AddrEvent: begin
        if (!w_empty) begin
          avs.readdata[DATA_WIDTH-1:0] = r_mem[r_rptr];
          // For DATA_WIDTH > 8 the count field overlays the upper head bits
          avs.readdata[8 +: CntW]      = r_count;
          avs.readdata[31]             = 1'b1;
        end
      end
      AddrStatus: begin
        avs.readdata[0] = r_overflow;
        avs.readdata[1] = w_full;
      end
      default: avs.readdata = '0;
    endcase
  end

endmodule
